// File: rtl/inst_fetch.sv
// Instruction fetch controller: reads one word at PC over a req/ack memory
// handshake, strobes it into the instruction register, then advances the PC.
module inst_fetch #(
    parameter int                   BUS_WIDTH = 32,
    parameter logic [BUS_WIDTH-1:0] RESET_PC  = '0,
    parameter int                   TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_start,
    input  logic                 pc_load,
    input  logic [BUS_WIDTH-1:0] pc_in,
    output logic                 mem_req,
    output logic [BUS_WIDTH-1:0] mem_addr,
    input  logic                 mem_ack,
    input  logic [BUS_WIDTH-1:0] mem_rdata,
    output logic [BUS_WIDTH-1:0] inst_out,
    output logic                 load_ir,
    output logic [BUS_WIDTH-1:0] pc,
    output logic                 busy,
    output logic                 fault
);

    typedef enum logic [1:0] {IDLE, REQ, DELIVER, FAULT} state_e;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_e               state_q, state_d;
    logic [BUS_WIDTH-1:0] pc_q, pc_d;
    logic [BUS_WIDTH-1:0] addr_q, addr_d;
    logic [BUS_WIDTH-1:0] inst_q, inst_d;
    logic                 req_q, req_d;
    logic                 load_q, load_d;
    logic                 fault_q, fault_d;
    logic [7:0]           cnt_q, cnt_d;

    logic [BUS_WIDTH-1:0] eff_addr;
    logic                 misaligned;
    logic [7:0]           cnt_inc;
    logic                 timeout_hit;

    // A same-cycle redirect supplies the fetch address directly.
    assign eff_addr    = pc_load ? pc_in : pc_q;
    assign misaligned  = |eff_addr[1:0];
    assign cnt_inc     = cnt_q + 8'd1;
    assign timeout_hit = (cnt_inc == TIMEOUT_C);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            inst_q  <= '0;
            req_q   <= 1'b0;
            load_q  <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            req_q   <= req_d;
            load_q  <= load_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, FAULT: if (fetch_start) state_d = misaligned ? FAULT : REQ;
            REQ: begin
                if (mem_ack)          state_d = DELIVER;
                else if (timeout_hit) state_d = FAULT;
            end
            DELIVER:     state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    // NOTE: every _d gets a hold default first, so no path through the case
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        pc_d    = pc_q;
        addr_d  = addr_q;
        inst_d  = inst_q;
        req_d   = req_q;
        load_d  = load_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, FAULT: begin
                if (pc_load) pc_d = pc_in;
                if (fetch_start) begin
                    fault_d = misaligned;
                    if (!misaligned) begin
                        req_d  = 1'b1;
                        addr_d = eff_addr;
                        cnt_d  = '0;
                    end
                end
            end
            REQ: begin
                if (mem_ack) begin
                    inst_d = mem_rdata;
                    req_d  = 1'b0;
                    load_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                    if (timeout_hit) begin
                        req_d   = 1'b0;
                        fault_d = 1'b1;
                    end
                end
            end
            DELIVER: begin
                load_d = 1'b0;
                pc_d   = addr_q + BUS_WIDTH'(4);
            end
            default: ;
        endcase
    end

    assign mem_req  = req_q;
    assign mem_addr = addr_q;
    assign inst_out = inst_q;
    assign load_ir  = load_q;
    assign pc       = pc_q;
    assign fault    = fault_q;
    assign busy     = (state_q == REQ) || (state_q == DELIVER);

endmodule
